// File: rtl/wide_add_ctrl_pkg.sv
// Shared types and constants for the word-serial wide adder.
package wide_add_ctrl_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_16bit.sv
// Single-word ripple adder shared across all operand words.
module adder_16bit
  import wide_add_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_cin,
  output logic [WORD_W-1:0] o_sum_c,
  output logic              o_cout_c
);

  assign {o_cout_c, o_sum_c} = (WORD_W+1)'(i_a) + (WORD_W+1)'(i_b) + (WORD_W+1)'(i_cin);

endmodule

// File: rtl/wide_add_ctrl.sv
// Word-serial add/subtract of two NUM_WORDS x 16-bit operands, LS word first.
module wide_add_ctrl
  import wide_add_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic                        sub,
  input  logic [WORD_W*NUM_WORDS-1:0] op_a,
  input  logic [WORD_W*NUM_WORDS-1:0] op_b,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_W*NUM_WORDS-1:0] result,
  output logic                        overflow
);

  localparam int unsigned DATA_W = WORD_W * NUM_WORDS;
  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_carry, w_carry_nxt;
  logic                r_sub, w_sub_nxt;
  logic [DATA_W-1:0]   r_a, w_a_nxt;
  logic [DATA_W-1:0]   r_b, w_b_nxt;
  logic [DATA_W-1:0]   r_result, w_result_nxt;
  logic                r_overflow, w_overflow_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;

  logic [WORD_W-1:0]   w_a_words [NUM_WORDS];
  logic [WORD_W-1:0]   w_b_words [NUM_WORDS];
  logic [WORD_W-1:0]   w_a_word, w_b_word, w_sum;
  logic                w_cout;

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
    assign w_a_words[g] = r_a[g*WORD_W +: WORD_W];
    assign w_b_words[g] = r_b[g*WORD_W +: WORD_W];
  end

  // Subtraction is A + ~B + 1; the +1 comes from the carry preset at capture.
  assign w_a_word = w_a_words[r_idx];
  assign w_b_word = r_sub ? ~w_b_words[r_idx] : w_b_words[r_idx];

  adder_16bit u_adder (
    .i_a      (w_a_word),
    .i_b      (w_b_word),
    .i_cin    (r_carry),
    .o_sum_c  (w_sum),
    .o_cout_c (w_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath-next logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_carry_nxt    = r_carry;
    w_sub_nxt      = r_sub;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_result_nxt   = r_result;
    w_overflow_nxt = r_overflow;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_nxt        = op_a;
          w_b_nxt        = op_b;
          w_sub_nxt      = sub;
          w_carry_nxt    = sub;
          w_idx_nxt      = '0;
          w_result_nxt   = '0;
          w_overflow_nxt = 1'b0;
          w_state_nxt    = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (r_idx == IDX_W'(i)) w_result_nxt[i*WORD_W +: WORD_W] = w_sum;
        end
        w_carry_nxt = w_cout;
        if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
          w_overflow_nxt = w_cout;
          w_idx_nxt      = '0;
          w_state_nxt    = DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_sub      <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_carry    <= w_carry_nxt;
      r_sub      <= w_sub_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_result   <= w_result_nxt;
      r_overflow <= w_overflow_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_wide_add_ctrl.sv
// Directed self-checking bench for wide_add_ctrl with NUM_WORDS=4.
module tb_wide_add_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        sub;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        overflow;

  int n_total = 0;
  int n_bad   = 0;

  wide_add_ctrl #(.NUM_WORDS(4)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge of the IDLE cycle after done.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic [63:0] exp_r, input logic exp_ov);
    int dc;
    dc    = 0;
    start = 1'b1;
    sub   = s;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    sub   = ~s;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_busy1"}, 64'(busy), 64'd1);
      if (done) begin
        dc = k;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(dc), 64'd5);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ov));
    @(negedge clk);
    chk({tag, "_done_off"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dones;
    int first_dc;

    n_rst = 1'b0;
    start = 1'b1;
    sub   = 1'b1;
    op_a  = '1;
    op_b  = 64'd1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res",  result, 64'd0);
    chk("rst_ovf",  64'(overflow), 64'd0);

    n_rst = 1'b1;
    run_op("ripple", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
    run_op("wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
    run_op("borrow", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("noborrow", 64'h7, 64'h5, 1'b1, 64'h2, 1'b1);
    run_op("mixed",  64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
           64'h2345_6789_ABCD_F001, 1'b0);

    // start re-pulsed in cycles 2 and 5 must be ignored.
    dones    = 0;
    first_dc = 0;
    start    = 1'b1;
    sub      = 1'b0;
    op_a     = 64'h10;
    op_b     = 64'h20;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (first_dc == 0) first_dc = k;
      end
      start = (k == 2 || k == 5);
      if (start) begin
        op_a = '1;
        op_b = 64'h1;
        sub  = 1'b1;
      end
    end
    start = 1'b0;
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_lat",   64'(first_dc), 64'd5);
    chk("ign_res",   result, 64'h30);
    chk("ign_ovf",   64'(overflow), 64'd0);

    // Reset during RUN cycle 2 aborts the operation.
    start = 1'b1;
    sub   = 1'b0;
    op_a  = 64'h1234;
    op_b  = 64'h1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("part_res",  result, 64'h1235);
    chk("part_busy", 64'(busy), 64'd1);
    n_rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res",  result, 64'd0);
    chk("abort_ovf",  64'(overflow), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    n_rst = 1'b1;
    run_op("after_rst", 64'hFFFF_FFFF, 64'h1, 1'b0, 64'h1_0000_0000, 1'b0);

    // Result holds in IDLE while inputs wander.
    run_op("pre_hold", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0003, 1'b0, 64'h3, 1'b1);
    for (int k = 0; k < 10; k++) begin
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      sub  = k[0];
      @(negedge clk);
    end
    chk("hold_res",  result, 64'h3);
    chk("hold_ovf",  64'(overflow), 64'd1);
    chk("hold_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
